// File: rtl/fbindct_bram_arb.sv
// Round-robin arbiter sharing one BRAM port between the DCT fetch path
// (m0) and the DCT writeback path (m1), with tagged read-data return.
module fbindct_bram_arb #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wrdata,
    output logic                  m0_gnt,
    output logic                  m0_rdvalid,
    output logic [DATA_WIDTH-1:0] m0_rddata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wrdata,
    output logic                  m1_gnt,
    output logic                  m1_rdvalid,
    output logic [DATA_WIDTH-1:0] m1_rddata,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wrdata,
    output logic                  bram_we,
    output logic                  bram_en,
    input  logic [DATA_WIDTH-1:0] bram_rddata
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef struct packed {
        logic v;
        logic id;
    } rd_tag_t;

    logic          owner, prev_gnt, last_owner;
    logic [CW-1:0] beat_cnt;
    logic          owner_n, prev_gnt_n, last_owner_n;
    logic [CW-1:0] beat_cnt_n;
    logic          gnt0, gnt1, any_gnt, lock;
    rd_tag_t       rd_pipe [RD_LATENCY];
    rd_tag_t       rd_tail;

    // Burst lock holds the port for the current owner under contention
    assign lock = prev_gnt && (beat_cnt < CNT_MAX);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            unique case (1'b1)
                (m0_req && !m1_req): gnt0 = 1'b1;
                (m1_req && !m0_req): gnt1 = 1'b1;
                (m0_req && m1_req): begin
                    gnt1 = lock ? owner : !last_owner;
                    gnt0 = !gnt1;
                end
                default: ;
            endcase
        end
    end

    assign any_gnt = gnt0 | gnt1;

    always_comb begin
        owner_n      = owner;
        last_owner_n = last_owner;
        prev_gnt_n   = 1'b0;
        beat_cnt_n   = '0;
        if (any_gnt) begin
            owner_n      = gnt1;
            last_owner_n = gnt1;
            prev_gnt_n   = 1'b1;
            if (!prev_gnt || (gnt1 != owner))
                beat_cnt_n = CW'(1);
            else if (beat_cnt < CNT_MAX)
                beat_cnt_n = beat_cnt + CW'(1);
            else
                beat_cnt_n = beat_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            prev_gnt   <= 1'b0;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            owner      <= owner_n;
            prev_gnt   <= prev_gnt_n;
            last_owner <= last_owner_n;
            beat_cnt   <= beat_cnt_n;
        end
    end

    always_comb begin
        bram_we     = 1'b0;
        bram_addr   = '0;
        bram_wrdata = '0;
        if (gnt0) begin
            bram_we     = m0_we;
            bram_addr   = m0_addr;
            bram_wrdata = m0_wrdata;
        end else if (gnt1) begin
            bram_we     = m1_we;
            bram_addr   = m1_addr;
            bram_wrdata = m1_wrdata;
        end
    end

    assign bram_en = any_gnt;
    assign m0_gnt  = gnt0;
    assign m1_gnt  = gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++)
                rd_pipe[i] <= '0;
        end else begin
            rd_pipe[0] <= '{v: any_gnt && !bram_we, id: gnt1};
            for (int i = 1; i < RD_LATENCY; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Gated by rst so reads issued just before reset never return
    assign rd_tail    = rd_pipe[RD_LATENCY-1];
    assign m0_rdvalid = !rst && rd_tail.v && !rd_tail.id;
    assign m1_rdvalid = !rst && rd_tail.v && rd_tail.id;
    assign m0_rddata  = bram_rddata;
    assign m1_rddata  = bram_rddata;

endmodule

// File: tb/tb_fbindct_bram_arb.sv
// Bench for fbindct_bram_arb: directed plan steps plus randomized
// masters, checked against a behavioural arbitration/memory model.
module tb_fbindct_bram_arb;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wrdata = '0;
    logic          m0_gnt, m0_rdvalid;
    logic [DW-1:0] m0_rddata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wrdata = '0;
    logic          m1_gnt, m1_rdvalid;
    logic [DW-1:0] m1_rddata;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wrdata;
    logic          bram_we, bram_en;
    logic [DW-1:0] bram_rddata;

    fbindct_bram_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MAX_BURST(MB), .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wrdata(m0_wrdata), .m0_gnt(m0_gnt),
        .m0_rdvalid(m0_rdvalid), .m0_rddata(m0_rddata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wrdata(m1_wrdata), .m1_gnt(m1_gnt),
        .m1_rdvalid(m1_rdvalid), .m1_rddata(m1_rddata),
        .bram_addr(bram_addr), .bram_wrdata(bram_wrdata),
        .bram_we(bram_we), .bram_en(bram_en),
        .bram_rddata(bram_rddata)
    );

    always #5 clk = ~clk;

    // BRAM: unwritten words read back as 0xA000_0000 | address
    logic [DW-1:0] mem [2**AW];
    bit            mem_w [2**AW];
    logic [DW-1:0] dl [RL];

    always @(posedge clk) begin
        if (bram_en && !bram_we)
            dl[0] <= mem_w[bram_addr] ? mem[bram_addr]
                                      : (32'hA000_0000 | DW'(bram_addr));
        for (int i = 1; i < RL; i++)
            dl[i] <= dl[i-1];
        if (bram_en && bram_we) begin
            mem[bram_addr]   <= bram_wrdata;
            mem_w[bram_addr] <= 1'b1;
        end
    end
    assign bram_rddata = dl[RL-1];

    // Reference model state
    int            checks = 0, errors = 0;
    int            mo_owner = 0, mo_prev = 0, mo_last = 1, mo_cnt = 0;
    bit            ep_v [RL];
    int            ep_id [RL];
    logic [DW-1:0] ep_d [RL];
    logic [DW-1:0] shadow [2**AW];
    int            last_win;
    logic          ob_g0, ob_g1, ob_en, ob_we, ob_rv0, ob_rv1;
    logic [AW-1:0] ob_addr;
    logic [DW-1:0] ob_wd, ob_rd0;
    logic [11:0]   gseq;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function int model_win();
        if (rst) return -1;
        if (m0_req && !m1_req) return 0;
        if (m1_req && !m0_req) return 1;
        if (m0_req && m1_req)
            return (mo_prev != 0 && mo_cnt < MB) ? mo_owner : 1 - mo_last;
        return -1;
    endfunction

    task automatic cyc();
        int            w;
        logic          xwe;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        bit            ev0, ev1;
        @(negedge clk);
        w   = model_win();
        xwe = (w == 0) ? m0_we : (w == 1) ? m1_we : 1'b0;
        xa  = (w == 0) ? m0_addr : (w == 1) ? m1_addr : '0;
        xd  = (w == 0) ? m0_wrdata : (w == 1) ? m1_wrdata : '0;
        ob_g0 = m0_gnt; ob_g1 = m1_gnt; ob_en = bram_en;
        ob_we = bram_we; ob_addr = bram_addr; ob_wd = bram_wrdata;
        ob_rv0 = m0_rdvalid; ob_rv1 = m1_rdvalid; ob_rd0 = m0_rddata;
        ev0 = !rst && ep_v[RL-1] && ep_id[RL-1] == 0;
        ev1 = !rst && ep_v[RL-1] && ep_id[RL-1] == 1;
        chk("m0_gnt", ob_g0, DW'(w == 0));
        chk("m1_gnt", ob_g1, DW'(w == 1));
        chk("bram_en", ob_en, DW'(w >= 0));
        chk("bram_we", ob_we, DW'(xwe));
        chk("bram_addr", ob_addr, DW'(xa));
        chk("bram_wrdata", ob_wd, xd);
        chk("m0_rdvalid", ob_rv0, DW'(ev0));
        chk("m1_rdvalid", ob_rv1, DW'(ev1));
        if (ev0) chk("m0_rddata", m0_rddata, ep_d[RL-1]);
        if (ev1) chk("m1_rddata", m1_rddata, ep_d[RL-1]);
        last_win = w;
        @(posedge clk);
        if (rst) begin
            mo_prev = 0; mo_cnt = 0; mo_last = 1;
            for (int i = 0; i < RL; i++) ep_v[i] = 1'b0;
        end else begin
            for (int i = RL - 1; i > 0; i--) begin
                ep_v[i] = ep_v[i-1]; ep_id[i] = ep_id[i-1]; ep_d[i] = ep_d[i-1];
            end
            ep_v[0]  = (w >= 0) && !xwe;
            ep_id[0] = w;
            ep_d[0]  = shadow[xa];
            if (w >= 0) begin
                if (xwe) shadow[xa] = xd;
                if (mo_prev == 0 || w != mo_owner) mo_cnt = 1;
                else mo_cnt = (mo_cnt < MB) ? mo_cnt + 1 : MB;
                mo_owner = w; mo_last = w; mo_prev = 1;
            end else begin
                mo_prev = 0; mo_cnt = 0;
            end
        end
        #1;
    endtask

    initial begin
        bit p0, p1;
        for (int i = 0; i < 2**AW; i++)
            shadow[i] = 32'hA000_0000 | i;

        // Reset with both masters requesting
        rst = 1'b1;
        m0_req = 1'b1; m0_addr = 13'h010;
        m1_req = 1'b1; m1_addr = 13'h310;
        repeat (3) begin
            cyc();
            chk("rst_en", ob_en, 0);
            chk("rst_gnt", {ob_g0, ob_g1}, 0);
            chk("rst_rdv", {ob_rv0, ob_rv1}, 0);
        end
        rst = 1'b0;

        // Continuous contention: m0 x4, m1 x4, m0 x4
        gseq = '0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (i == 0) chk("first_gnt_m0", ob_g0, 1);
            chk("cont_en", ob_en, 1);
            gseq = {gseq[10:0], ob_g1};
        end
        chk("cont_seq", gseq, 12'b0000_1111_0000);
        m0_req = 1'b0; m1_req = 1'b0;
        cyc(); cyc();

        // Single read
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 13'h005;
        cyc();
        chk("rd_en", ob_en, 1);
        chk("rd_addr", ob_addr, 13'h005);
        m0_req = 1'b0;
        cyc();
        chk("rd_rv0", ob_rv0, 1);
        chk("rd_data", ob_rd0, 32'hA000_0005);
        chk("rd_rv1", ob_rv1, 0);

        // Write passthrough from m1
        m1_req = 1'b1; m1_we = 1'b1;
        m1_addr = 13'h300; m1_wrdata = 32'hDEAD_BEEF;
        cyc();
        chk("wr_gnt", ob_g1, 1);
        chk("wr_we", ob_we, 1);
        chk("wr_addr", ob_addr, 13'h300);
        chk("wr_data", ob_wd, 32'hDEAD_BEEF);
        m1_req = 1'b0; m1_we = 1'b0;
        cyc();
        chk("wr_no_rdv", {ob_rv0, ob_rv1}, 0);

        // Early release: m0 two beats, then m1 starts a fresh burst
        m0_req = 1'b1; m0_addr = 13'h020;
        m1_req = 1'b1; m1_addr = 13'h300;
        cyc(); chk("rel_b1", ob_g0, 1);
        cyc(); chk("rel_b2", ob_g0, 1);
        m0_req = 1'b0;
        cyc(); chk("rel_m1", ob_g1, 1);
        m0_req = 1'b1;
        gseq = '0;
        repeat (4) begin
            cyc();
            gseq = {gseq[10:0], ob_g1};
        end
        chk("rel_lock", gseq[3:0], 4'b1110);
        m0_req = 1'b0; m1_req = 1'b0;
        cyc();

        // Reset flush of an in-flight read
        m0_req = 1'b1; m0_addr = 13'h007;
        cyc(); chk("fl_gnt", ob_g0, 1);
        m0_req = 1'b0; rst = 1'b1;
        cyc(); chk("fl_rv_r1", ob_rv0, 0);
        cyc(); chk("fl_rv_r2", ob_rv0, 0);
        rst = 1'b0;
        cyc(); chk("fl_rv_a1", ob_rv0, 0);
        cyc(); chk("fl_rv_a2", ob_rv0, 0);

        // Randomized masters following the hold-until-grant protocol
        p0 = 1'b0; p1 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 200 == 0);
            if (!p0 && $urandom % 4 != 0) begin
                m0_req = 1'b1; m0_we = ($urandom % 3 == 0);
                m0_addr = AW'($urandom % 64); m0_wrdata = $urandom;
                p0 = 1'b1;
            end
            if (!p1 && $urandom % 4 != 0) begin
                m1_req = 1'b1; m1_we = ($urandom % 3 == 0);
                m1_addr = AW'($urandom % 64); m1_wrdata = $urandom;
                p1 = 1'b1;
            end
            cyc();
            if (last_win == 0) begin p0 = 1'b0; m0_req = 1'b0; end
            if (last_win == 1) begin p1 = 1'b0; m1_req = 1'b0; end
        end
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fbindct_bram_arb.md
Name: fbindct_bram_arb

Overview:
- Two-master arbiter that shares the single PL-side BRAM port between the DCT input fetch path (master 0, reads ping-pong buffers A/B) and the DCT result writeback path (master 1, reads/writes the output region).
- Grant is decided combinationally in the request cycle.
- Round-robin arbitration with a bounded burst lock.
- Read data is tagged and routed back to the issuing master after a fixed BRAM latency.

Parameters:
- ADDR_WIDTH, 13, BRAM word address width
- DATA_WIDTH, 32, BRAM data width
- MAX_BURST, 4, max consecutive beats a master keeps the port while the other master is requesting (>=1)
- RD_LATENCY, 1, cycles from accepted read to bram_rddata valid (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  master 0 access request, one beat per cycle
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  ADDR_WIDTH  master 0 address
- m0_wrdata  in  DATA_WIDTH  master 0 write data
- m0_gnt  out  1  beat accepted this cycle (combinational)
- m0_rdvalid  out  1  read data valid for master 0
- m0_rddata  out  DATA_WIDTH  read data for master 0
- m1_req, m1_we, m1_addr, m1_wrdata, m1_gnt, m1_rdvalid, m1_rddata: same as master 0, for master 1
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_wrdata  out  DATA_WIDTH  BRAM write data
- bram_we  out  1  BRAM write enable
- bram_en  out  1  BRAM enable
- bram_rddata  in  DATA_WIDTH  BRAM read data

Behaviour:
- State registers:
  - owner: master granted last cycle
  - prev_gnt: a grant occurred last cycle
  - last_owner: most recent master ever granted
  - beat_cnt: consecutive beats to owner, saturates at MAX_BURST
  - rd pipeline: RD_LATENCY-deep shift register of {valid, id}
- Reset values:
  - prev_gnt=0, beat_cnt=0, last_owner=1 (master 0 wins the first tie), rd pipeline all invalid.
  - Outputs: m*_gnt=0, m*_rdvalid=0, bram_en=0, bram_we=0.
- Grant rule (combinational, evaluated each cycle):
  - No request: no grant; next prev_gnt=0, beat_cnt=0.
  - Exactly one requester: grant it.
  - Both requesting, prev_gnt=1 and beat_cnt<MAX_BURST: grant owner (burst lock).
  - Both requesting otherwise: grant ~last_owner.
  - At most one gnt high per cycle.
- Counter update on a grant to X:
  - beat_cnt = 1 if (!prev_gnt or X!=owner), else min(beat_cnt+1, MAX_BURST).
  - owner=X, last_owner=X, prev_gnt=1.
- A lone requester is never starved by the lock. Saturation lets it keep streaming indefinitely until the other master requests.
- Port mux:
  - bram_en = any grant.
  - bram_we, bram_addr, bram_wrdata come from the granted master in the same cycle.
  - With no grant, bram_we=0 and bram_addr/bram_wrdata=0.
- Read return:
  - An accepted read (gnt & !we) pushes {1, id} into the pipeline; writes push invalid.
  - After RD_LATENCY cycles, m<id>_rdvalid=1 for one cycle with m<id>_rddata=bram_rddata.
  - The non-target master's rdvalid stays 0.
  - m*_rddata is bram_rddata passed through; it is valid only with rdvalid.
- Back-to-back reads, including reads alternating between masters, return in issue order with no bubbles.
- Masters hold req/we/addr/wrdata stable until gnt; a beat not granted is retried next cycle.
- Reset mid-operation: the in-flight read pipeline is cleared. No rdvalid pulse may appear for reads accepted before rst.

Test Plan:
- Reset check: hold rst 3 cycles with m0_req=m1_req=1 -> bram_en=0, both gnt=0 under rst, both rdvalid=0; the first cycle after release grants m0.
- Single read: memory[0x005]=0xA0000005; m0 reads 0x005 for one beat -> bram_en=1, bram_addr=0x005 same cycle; m0_rdvalid=1 with m0_rddata=0xA0000005 exactly 1 cycle later; m1_rdvalid=0.
- Contention, MAX_BURST=4: both masters request continuously -> grants are m0×4, m1×4, m0×4; no idle cycle on bram_en.
- Write passthrough: m1 writes 0x300 with data 0xDEADBEEF while m0 is idle -> bram_we=1, bram_addr=0x300, bram_wrdata=0xDEADBEEF, m1_gnt=1 same cycle; no rdvalid pulse.
- Early release: m0 holds the port for 2 beats, then drops req while m1 is waiting -> m1_gnt=1 in the next cycle, with beat_cnt=1.
- Reset flush: m0 read accepted, rst asserted the following cycle -> m0_rdvalid stays 0 through and after reset.
